// File: rtl/zeroriscy_prefetch_buf.sv
`default_nettype none
// ============================================================================
// zeroriscy_prefetch_buf : sequential instruction prefetcher with a flushable
//   FIFO. Optional macro PREFETCH_ERR_EN stores a bus-error bit per entry.
// Revision 1.0 - initial release
// ============================================================================
module zeroriscy_prefetch_buf #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_MAX_OUTST = CW'(MAX_OUTST);
  localparam logic [CW:0]   C_DEPTH     = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);

  logic [31:0]   rdata_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] fifo_cnt_next;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] discard;
  logic [CW:0]   credit_used;
  logic [31:0]   fetch_addr;
  logic [31:0]   resp_addr;
  logic          branch;
  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic [1:0]    unused_addr_bits;

  assign unused_addr_bits = addr_i[1:0];

  assign branch      = req_i & branch_i;
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, outst};
  // Credit check keeps FIFO entries plus in-flight requests within DEPTH,
  // so a returning word always has a free slot.
  assign instr_req_o  = req_i & ~branch_i & (outst < C_MAX_OUTST) & (credit_used < C_DEPTH);
  assign instr_addr_o = fetch_addr;

  assign grant   = instr_req_o & instr_gnt_i;
  assign resp    = instr_rvalid_i & (outst != '0);
  assign push    = resp & (discard == '0) & ~branch;
  assign valid_o = (fifo_cnt != '0);
  assign pop     = valid_o & ready_i & ~branch;
  assign rdata_o = rdata_mem[rd_ptr];
  assign addr_o  = addr_mem[rd_ptr];

  always_comb begin
    outst_next    = outst;
    fifo_cnt_next = fifo_cnt;
    if (grant && !resp) begin
      outst_next = outst + C_ONE;
    end else if (!grant && resp) begin
      outst_next = outst - C_ONE;
    end
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt + C_ONE;
    end else if (!push && pop) begin
      fifo_cnt_next = fifo_cnt - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      outst      <= '0;
      discard    <= '0;
      fetch_addr <= '0;
      resp_addr  <= '0;
    end else begin
      outst <= outst_next;
      if (branch) begin
        // Everything still in flight belongs to the old path.
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_cnt   <= '0;
        discard    <= outst_next;
        fetch_addr <= {addr_i[31:2], 2'b00};
        resp_addr  <= {addr_i[31:2], 2'b00};
      end else begin
        fifo_cnt <= fifo_cnt_next;
        if (grant) fetch_addr <= fetch_addr + 32'd4;
        if (push) begin
          wr_ptr    <= wr_ptr + C_PTR_ONE;
          resp_addr <= resp_addr + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + C_PTR_ONE;
        if (resp && discard != '0) discard <= discard - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdata_mem[wr_ptr] <= instr_rdata_i;
      addr_mem[wr_ptr]  <= resp_addr;
    end
  end

`ifdef PREFETCH_ERR_EN
  logic err_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) err_mem[wr_ptr] <= instr_err_i;
  end

  assign err_o = valid_o & err_mem[rd_ptr];
`else
  logic unused_err;

  assign unused_err = instr_err_i;
  assign err_o      = 1'b0;
`endif

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(instr_rvalid_i && outst == '0));
  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && {1'b0, fifo_cnt} == C_DEPTH));

endmodule
`default_nettype wire
